frame_shift_register: RTL and testbench

Parametrised serial-in/serial-out/parallel-load shift register with a frame bit counter and a valid/ready handshake on the parallel output. It extends the CPU's 16-bit serial shifter to any width and either shift direction. It also adds frame completion, back-pressure and overrun detection. It sits between serial front-ends (UART/SPI-style bit streams, boot loaders) and word-wide consumers such as instruction/data load paths.

---
 rtl/frame_shift_register.sv | 78 +++++++
 tb/tb_frame_shift_register.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_shift_register.sv
// Parametrised serial-in/serial-out/parallel-load shift register with a frame
// bit counter, valid/ready handshake on the parallel word and a sticky overrun flag.
module frame_shift_register #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] par_o,
    output logic [CW-1:0]    count_o,
    output logic             frame_valid_o,
    input  logic             frame_ready_i,
    output logic             overrun_o
);

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    count;
    logic             overrun;
    logic             valid;
    logic             stall;

    // A frame is held exactly while the counter sits at WIDTH, so no separate valid flop.
    assign valid = (count == FULL);
    assign stall = valid & ~frame_ready_i;

    always_comb begin
        shift_next = shift_s;
        if (MSB_FIRST) begin
            shift_next = {shift_s[WIDTH-2:0], ser_i};
        end else begin
            shift_next = {ser_i, shift_s[WIDTH-1:1]};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shift_s <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clr_i) begin
            shift_s <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (load_i) begin
            shift_s <= load_data_i;
            count   <= '0;
            overrun <= 1'b0;
        end else if (stall) begin
            if (shift_en_i) begin
                overrun <= 1'b1;
            end
        end else if (shift_en_i) begin
            // On accept the counter restarts, so a same-cycle shift lands as bit 1 of the next frame.
            shift_s <= shift_next;
            count   <= (valid ? '0 : count) + CW'(1);
        end else if (valid) begin
            count <= '0;
        end
    end

    assign ser_o         = MSB_FIRST ? shift_s[WIDTH-1] : shift_s[0];
    assign par_o         = shift_s;
    assign count_o       = count;
    assign frame_valid_o = valid;
    assign overrun_o     = overrun;

endmodule

// File: tb/tb_frame_shift_register.sv
// Self-checking bench: a 16-bit MSB-first and an 8-bit LSB-first instance, directed
// scenarios plus randomized traffic compared against an arithmetic reference model.
module tb_frame_shift_register;

    localparam int WA = 16;
    localparam int WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb;

    logic        a_clr, a_load, a_sh, a_ser, a_rdy;
    logic [15:0] a_ld;
    logic        a_ser_o, a_val, a_ovr;
    logic [15:0] a_par;
    logic [4:0]  a_cnt;

    logic        b_clr, b_load, b_sh, b_ser, b_rdy;
    logic [7:0]  b_ld;
    logic        b_ser_o, b_val, b_ovr;
    logic [7:0]  b_par;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state (plain integers / wide vectors)
    logic [63:0] ma_val, mb_val;
    int          ma_cnt, mb_cnt;
    bit          ma_ovr, mb_ovr;

    frame_shift_register #(.WIDTH(WA), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .resetb(resetb), .clr_i(a_clr), .load_i(a_load), .load_data_i(a_ld),
        .shift_en_i(a_sh), .ser_i(a_ser), .ser_o(a_ser_o), .par_o(a_par), .count_o(a_cnt),
        .frame_valid_o(a_val), .frame_ready_i(a_rdy), .overrun_o(a_ovr)
    );

    frame_shift_register #(.WIDTH(WB), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .resetb(resetb), .clr_i(b_clr), .load_i(b_load), .load_data_i(b_ld),
        .shift_en_i(b_sh), .ser_i(b_ser), .ser_o(b_ser_o), .par_o(b_par), .count_o(b_cnt),
        .frame_valid_o(b_val), .frame_ready_i(b_rdy), .overrun_o(b_ovr)
    );

    // One clock of the specification's rules, expressed on integers.
    task automatic model_step(input int w, input bit msb, input bit clr, input bit load,
                              input logic [63:0] ld, input bit sh, input bit ser, input bit rdy,
                              inout logic [63:0] val, inout int cnt, inout bit ovr);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (clr) begin
            val = '0; cnt = 0; ovr = 1'b0;
        end else if (load) begin
            val = ld & mask; cnt = 0; ovr = 1'b0;
        end else if (cnt == w && !rdy) begin
            if (sh) ovr = 1'b1;
        end else begin
            if (cnt == w) cnt = 0;
            if (sh) begin
                if (msb) val = ((val * 2) + 64'(ser)) & mask;
                else     val = (val / 2) + (64'(ser) << (w - 1));
                cnt = cnt + 1;
            end
        end
    endtask

    task automatic cyc_a(input bit clr, input bit load, input logic [15:0] ld,
                         input bit sh, input bit ser, input bit rdy);
        a_clr = clr; a_load = load; a_ld = ld; a_sh = sh; a_ser = ser; a_rdy = rdy;
        @(posedge clk);
        model_step(WA, 1'b1, clr, load, {48'd0, ld}, sh, ser, rdy, ma_val, ma_cnt, ma_ovr);
        #1;
        a_clr = 1'b0; a_load = 1'b0; a_sh = 1'b0; a_rdy = 1'b0;
    endtask

    task automatic cyc_b(input bit clr, input bit load, input logic [7:0] ld,
                         input bit sh, input bit ser, input bit rdy);
        b_clr = clr; b_load = load; b_ld = ld; b_sh = sh; b_ser = ser; b_rdy = rdy;
        @(posedge clk);
        model_step(WB, 1'b0, clr, load, {56'd0, ld}, sh, ser, rdy, mb_val, mb_cnt, mb_ovr);
        #1;
        b_clr = 1'b0; b_load = 1'b0; b_sh = 1'b0; b_rdy = 1'b0;
    endtask

    task automatic models_reset();
        ma_val = '0; ma_cnt = 0; ma_ovr = 1'b0;
        mb_val = '0; mb_cnt = 0; mb_ovr = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b1;
        #3;
        resetb = 1'b0;
        models_reset();
        for (int i = 0; i < 6; i++) begin
            a_clr = 1'($urandom); a_load = 1'($urandom); a_ld = 16'($urandom);
            a_sh = 1'($urandom); a_ser = 1'($urandom); a_rdy = 1'($urandom);
            b_clr = 1'($urandom); b_load = 1'($urandom); b_ld = 8'($urandom);
            b_sh = 1'($urandom); b_ser = 1'($urandom); b_rdy = 1'($urandom);
            #1;
            checks++;
            if ({a_par, a_cnt, a_val, a_ovr, a_ser_o} !== '0) begin
                errors++;
                $display("FAIL reset_a[%0d]: par=%h cnt=%0d val=%b ovr=%b ser=%b, required all 0",
                         i, a_par, a_cnt, a_val, a_ovr, a_ser_o);
            end
            checks++;
            if ({b_par, b_cnt, b_val, b_ovr, b_ser_o} !== '0) begin
                errors++;
                $display("FAIL reset_b[%0d]: par=%h cnt=%0d val=%b ovr=%b ser=%b, required all 0",
                         i, b_par, b_cnt, b_val, b_ovr, b_ser_o);
            end
            @(negedge clk);
        end
        a_clr = 0; a_load = 0; a_sh = 0; a_ser = 0; a_rdy = 0; a_ld = '0;
        b_clr = 0; b_load = 0; b_sh = 0; b_ser = 0; b_rdy = 0; b_ld = '0;
        resetb = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({a_par, a_cnt, a_val, a_ovr, a_ser_o, b_par, b_cnt, b_val, b_ovr, b_ser_o} !== '0) begin
            errors++;
            $display("FAIL reset_release: a_par=%h a_cnt=%0d b_par=%h b_cnt=%0d, required all 0",
                     a_par, a_cnt, b_par, b_cnt);
        end
    endtask

    task automatic test_serial_frame();
        logic [15:0] data;
        data = 16'hA5C3;
        for (int i = 15; i >= 0; i--) begin
            cyc_a(0, 0, '0, 1, data[i], 0);
            if (i == 1) begin
                checks++;
                if (a_val !== 1'b0 || a_cnt !== 5'd15) begin
                    errors++;
                    $display("FAIL frame_early: val=%b cnt=%0d, required val=0 cnt=15", a_val, a_cnt);
                end
            end
        end
        checks++;
        if (a_val !== 1'b1 || a_par !== 16'hA5C3 || a_cnt !== 5'd16 || a_ovr !== 1'b0) begin
            errors++;
            $display("FAIL frame_done: val=%b par=%h cnt=%0d ovr=%b, required 1 a5c3 16 0",
                     a_val, a_par, a_cnt, a_ovr);
        end
    endtask

    task automatic test_load_shift_out();
        logic [3:0] exp_ser;
        exp_ser = 4'b1000;
        cyc_a(0, 1, 16'h8001, 0, 0, 0);
        checks++;
        if (a_par !== 16'h8001 || a_cnt !== 5'd0 || a_val !== 1'b0) begin
            errors++;
            $display("FAIL load: par=%h cnt=%0d val=%b, required 8001 0 0", a_par, a_cnt, a_val);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_ser_o !== exp_ser[3-k]) begin
                errors++;
                $display("FAIL ser_out[%0d]: got %b, required %b", k, a_ser_o, exp_ser[3-k]);
            end
            cyc_a(0, 0, '0, 1, 0, 0);
        end
        checks++;
        if (a_par !== 16'h0010 || a_cnt !== 5'd4 || a_val !== 1'b0) begin
            errors++;
            $display("FAIL load_shift: par=%h cnt=%0d val=%b, required 0010 4 0", a_par, a_cnt, a_val);
        end
    endtask

    task automatic test_stall_overrun();
        logic [15:0] data;
        data = 16'hA5C3;
        cyc_a(1, 0, '0, 0, 0, 0);
        for (int i = 15; i >= 0; i--) cyc_a(0, 0, '0, 1, data[i], 0);
        for (int i = 0; i < 3; i++) begin
            cyc_a(0, 0, '0, 1, 1, 0);
            checks++;
            if (a_par !== 16'hA5C3 || a_cnt !== 5'd16 || a_val !== 1'b1 || a_ovr !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: par=%h cnt=%0d val=%b ovr=%b, required a5c3 16 1 1",
                         i, a_par, a_cnt, a_val, a_ovr);
            end
        end
        cyc_a(0, 0, '0, 0, 0, 1);
        checks++;
        if (a_val !== 1'b0 || a_cnt !== 5'd0 || a_ovr !== 1'b1 || a_par !== 16'hA5C3) begin
            errors++;
            $display("FAIL accept: val=%b cnt=%0d ovr=%b par=%h, required 0 0 1 a5c3",
                     a_val, a_cnt, a_ovr, a_par);
        end
        cyc_a(0, 0, '0, 1, 1, 0);
        checks++;
        if (a_ovr !== 1'b1 || a_cnt !== 5'd1 || a_par !== 16'h4B87) begin
            errors++;
            $display("FAIL ovr_sticky: ovr=%b cnt=%0d par=%h, required 1 1 4b87", a_ovr, a_cnt, a_par);
        end
        cyc_a(0, 1, 16'h0000, 0, 0, 0);
        checks++;
        if (a_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_load_clear: ovr=%b, required 0", a_ovr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream;
        int pulses;
        stream = {16'h1234, 16'hFEDC};
        pulses = 0;
        cyc_a(1, 0, '0, 0, 0, 0);
        for (int step = 1; step <= 32; step++) begin
            cyc_a(0, 0, '0, 1, stream[32-step], 1);
            checks++;
            if (a_val !== ((step == 16) || (step == 32))) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: val=%b", step, a_val);
            end
            if (a_val === 1'b1) begin
                pulses++;
                checks++;
                if (a_par !== (pulses == 1 ? 16'h1234 : 16'hFEDC) || a_cnt !== 5'd16) begin
                    errors++;
                    $display("FAIL b2b_word[%0d]: par=%h cnt=%0d", pulses, a_par, a_cnt);
                end
            end
            if (step == 17) begin
                checks++;
                if (a_cnt !== 5'd1) begin
                    errors++;
                    $display("FAIL b2b_count: cnt=%0d, required 1", a_cnt);
                end
            end
        end
        cyc_a(0, 0, '0, 0, 0, 1);
        checks++;
        if (pulses != 2 || a_ovr !== 1'b0 || a_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: pulses=%0d ovr=%b val=%b, required 2 0 0", pulses, a_ovr, a_val);
        end
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 400; i++) begin
            cyc_a(($urandom_range(63) == 0), ($urandom_range(31) == 0), 16'($urandom),
                  ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
            checks++;
            if (a_par !== ma_val[15:0] || a_cnt !== 5'(ma_cnt) || a_val !== (ma_cnt == WA) ||
                a_ovr !== ma_ovr || a_ser_o !== ma_val[WA-1]) begin
                errors++;
                $display("FAIL rand_a[%0d]: par=%h cnt=%0d val=%b ovr=%b, required %h %0d %b %b",
                         i, a_par, a_cnt, a_val, a_ovr, ma_val[15:0], ma_cnt, (ma_cnt == WA), ma_ovr);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] data;
        data = 8'h5A;
        for (int i = 0; i < 8; i++) cyc_b(0, 0, '0, 1, data[i], 0);
        checks++;
        if (b_par !== 8'h5A || b_val !== 1'b1 || b_cnt !== 4'd8 || b_ser_o !== 1'b0) begin
            errors++;
            $display("FAIL lsb_frame: par=%h val=%b cnt=%0d ser=%b, required 5a 1 8 0",
                     b_par, b_val, b_cnt, b_ser_o);
        end
        cyc_b(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc_b(0, 0, '0, 1, 1, 0);
        checks++;
        if (b_cnt !== 4'd5 || b_val !== 1'b0) begin
            errors++;
            $display("FAIL lsb_partial: cnt=%0d val=%b, required 5 0", b_cnt, b_val);
        end
        #2;
        resetb = 1'b0;
        models_reset();
        #1;
        checks++;
        if ({b_par, b_cnt, b_val, b_ovr, b_ser_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: par=%h cnt=%0d val=%b ovr=%b ser=%b, required all 0",
                     b_par, b_cnt, b_val, b_ovr, b_ser_o);
        end
        @(negedge clk);
        resetb = 1'b1;
        data = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            cyc_b(0, 0, '0, 1, data[i], 0);
            if (i == 6) begin
                checks++;
                if (b_cnt !== 4'd7 || b_val !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset_count: cnt=%0d val=%b, required 7 0", b_cnt, b_val);
                end
            end
        end
        checks++;
        if (b_par !== 8'hC3 || b_val !== 1'b1 || b_cnt !== 4'd8) begin
            errors++;
            $display("FAIL post_reset_frame: par=%h val=%b cnt=%0d, required c3 1 8", b_par, b_val, b_cnt);
        end
    endtask

    task automatic test_random_b();
        for (int i = 0; i < 300; i++) begin
            cyc_b(($urandom_range(63) == 0), ($urandom_range(31) == 0), 8'($urandom),
                  ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
            checks++;
            if (b_par !== mb_val[7:0] || b_cnt !== 4'(mb_cnt) || b_val !== (mb_cnt == WB) ||
                b_ovr !== mb_ovr || b_ser_o !== mb_val[0]) begin
                errors++;
                $display("FAIL rand_b[%0d]: par=%h cnt=%0d val=%b ovr=%b, required %h %0d %b %b",
                         i, b_par, b_cnt, b_val, b_ovr, mb_val[7:0], mb_cnt, (mb_cnt == WB), mb_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serial_frame();
        test_load_shift_out();
        test_stall_overrun();
        test_back_to_back();
        test_random_a();
        test_lsb_first();
        test_random_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
